// File: rtl/seven_pkg.sv
// Shared glyph tables, helpers and converter state type for the seven_mux display driver.
// No logic of its own; glyphs are active-high {g,f,e,d,c,b,a}.
package seven_pkg;

  // Indexed by nibble value; the seven includes segment f.
  localparam logic [15:0][6:0] GLYPH_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h27, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  localparam logic [6:0] GLYPH_DASH  = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } conv_state_t;

  function automatic logic [6:0] hex_to_glyph(input logic [3:0] nib);
    return GLYPH_HEX[nib];
  endfunction

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/seven_bin2bcd.sv
// Free-running binary-to-BCD/nibble converter: capture, DATA_W double-dabble shifts, commit.
// Latency capture->done: DATA_W+1 cycles decimal, 1 cycle hex; no backpressure, done is a 1-cycle strobe.
module seven_bin2bcd
  import seven_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [DATA_W-1:0]          data,
  input  logic                       hex_mode,
  output logic                       done,
  output logic [NUM_DIGITS-1:0][3:0] digits,
  output logic                       ovf
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [63:0] DEC_MAX = pow10(NUM_DIGITS) - 64'd1;

  conv_state_t       state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [BCD_W-1:0]  bcd, bcd_adj;
  logic [CNT_W-1:0]  cnt;
  logic              hex_ovf, dec_ovf;

  if (DATA_W > BCD_W) begin : g_hex_ovf
    assign hex_ovf = |data[DATA_W-1:BCD_W];
  end else begin : g_no_hex_ovf
    assign hex_ovf = 1'b0;
  end

  assign dec_ovf = 64'(data) > DEC_MAX;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = hex_mode ? COMMIT : SHIFT;
      SHIFT:   if (cnt == CNT_W'(DATA_W - 1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      bcd   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= data;
            cnt   <= '0;
            bcd   <= hex_mode ? BCD_W'(data) : '0;
            ovf   <= hex_mode ? hex_ovf : dec_ovf;
          end
        end
        SHIFT: begin
          // Digits carried out of the top are lost; the overflow flag covers that case.
          bcd   <= {bcd_adj[BCD_W-2:0], shreg[DATA_W-1]};
          shreg <= shreg << 1;
          cnt   <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done   = (state == COMMIT);
  assign digits = bcd;

endmodule

// File: rtl/seven_mux.sv
// Multiplexed N-digit 7-segment driver: converter feeds tear-free display registers, scanned per DIGIT_TICKS.
// Outputs registered, 1 cycle from display state/blank_lz/dp; no backpressure, conversion free-runs.
module seven_mux
  import seven_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int DATA_W           = 32,
  parameter int DIGIT_TICKS      = 100000,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     data_seg,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic                  overflow,
  output logic                  bcd_valid
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TICK_W = $clog2(DIGIT_TICKS);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW != 0}};
  localparam logic [6:0]            SEG_OFF   = {7{SEG_ACTIVE_LOW != 0}};

  logic                       conv_done, conv_ovf;
  logic [NUM_DIGITS-1:0][3:0] conv_digits, disp;
  logic                       disp_ovf;
  logic [TICK_W-1:0]          tick;
  logic [IDX_W-1:0]           idx;
  logic [NUM_DIGITS-1:0]      lz_zero;
  logic [NUM_DIGITS-1:0]      onehot;
  logic [6:0]                 glyph;

  seven_bin2bcd #(
    .NUM_DIGITS(NUM_DIGITS),
    .DATA_W    (DATA_W)
  ) u_conv (
    .clk     (clk),
    .rst     (rst),
    .start   (1'b1),
    .data    (data_seg),
    .hex_mode(hex_mode),
    .done    (conv_done),
    .digits  (conv_digits),
    .ovf     (conv_ovf)
  );

  // lz_zero[i]: digit i and every digit above it are zero.
  always_comb begin
    lz_zero = '0;
    lz_zero[NUM_DIGITS-1] = (disp[NUM_DIGITS-1] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      lz_zero[i] = lz_zero[i+1] && (disp[i] == 4'd0);
    end
  end

  always_comb begin
    glyph = hex_to_glyph(disp[idx]);
    if (disp_ovf) glyph = GLYPH_DASH;
    else if (blank_lz && (idx != '0) && lz_zero[idx]) glyph = GLYPH_BLANK;
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick      <= '0;
      idx       <= '0;
      disp      <= '0;
      disp_ovf  <= 1'b0;
      bcd_valid <= 1'b0;
      anode     <= ANODE_OFF;
      seg       <= SEG_OFF;
      dp_out    <= SEG_OFF[0];
    end else begin
      if (tick == TICK_W'(DIGIT_TICKS - 1)) begin
        tick <= '0;
        idx  <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        tick <= tick + 1'b1;
      end
      bcd_valid <= conv_done;
      if (conv_done) begin
        disp     <= conv_digits;
        disp_ovf <= conv_ovf;
      end
      anode  <= onehot ^ ANODE_OFF;
      seg    <= glyph ^ SEG_OFF;
      dp_out <= dp[idx] ^ SEG_OFF[0];
    end
  end

  assign overflow = disp_ovf;

endmodule

// File: tb/tb_seven_mux.sv
// Randomized bench for seven_mux against a divide/modulo display model.
module tb_seven_mux;
  localparam int ND = 4;
  localparam int DW = 32;
  localparam int DT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_seg;
  logic          hex_mode;
  logic          blank_lz;
  logic [ND-1:0] dp;
  logic [ND-1:0] anode;
  logic [6:0]    seg;
  logic          dp_out;
  logic          overflow;
  logic          bcd_valid;

  int checks   = 0;
  int failures = 0;

  // Active-high {g,f,e,d,c,b,a} for 0..F
  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [6:0] obs_seg [ND];
  logic       obs_dp  [ND];
  int         obs_bad;

  always #5 clk = ~clk;

  seven_mux #(
    .NUM_DIGITS(ND), .DATA_W(DW), .DIGIT_TICKS(DT),
    .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .data_seg(data_seg), .hex_mode(hex_mode),
    .blank_lz(blank_lz), .dp(dp), .anode(anode), .seg(seg),
    .dp_out(dp_out), .overflow(overflow), .bcd_valid(bcd_valid)
  );

  function automatic bit exp_ovf(input longint unsigned v, input bit hex);
    longint unsigned lim;
    lim = 1;
    for (int k = 0; k < ND; k++) lim = lim * (hex ? 16 : 10);
    return v >= lim;
  endfunction

  // Expected active-low seg pins for digit position pos.
  function automatic logic [6:0] exp_seg(input longint unsigned v, input bit hex,
                                         input bit blank, input int pos);
    longint unsigned base, p;
    int d;
    base = hex ? 16 : 10;
    p = 1;
    for (int k = 0; k < pos; k++) p = p * base;
    if (exp_ovf(v, hex)) return 7'h3F;
    if (blank && pos > 0 && v < p) return 7'h7F;
    d = int'((v / p) % base);
    return ~glyph_tab[d];
  endfunction

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bcd_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Apply a value, then wait until a commit built from it has landed.
  task automatic settle(input logic [DW-1:0] v, input bit hex, output bit ok);
    bit ok1, ok2;
    data_seg = v;
    hex_mode = hex;
    wait_valid(ok1);
    wait_valid(ok2);
    ok = ok1 && ok2;
  endtask

  // One full scan: last seg/dp seen per active digit, count of non-one-hot anode samples.
  task automatic observe();
    obs_bad = 0;
    for (int k = 0; k < ND; k++) begin
      obs_seg[k] = 'x;
      obs_dp[k]  = 1'bx;
    end
    for (int n = 0; n < ND * DT; n++) begin
      @(negedge clk);
      case (anode)
        4'b1110: begin obs_seg[0] = seg; obs_dp[0] = dp_out; end
        4'b1101: begin obs_seg[1] = seg; obs_dp[1] = dp_out; end
        4'b1011: begin obs_seg[2] = seg; obs_dp[2] = dp_out; end
        4'b0111: begin obs_seg[3] = seg; obs_dp[3] = dp_out; end
        default: obs_bad++;
      endcase
    end
  endtask

  task automatic test_reset();
    int first_valid;
    logic [ND-1:0] exp_an;
    rst = 1'b1; data_seg = 32'd1234; hex_mode = 1'b0; blank_lz = 1'b0; dp = '0;
    repeat (3) @(negedge clk);
    checks++; if (anode !== 4'hF) begin failures++; $display("FAIL reset_anode got=%b exp=1111", anode); end
    checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%b exp=1111111", seg); end
    checks++; if (dp_out !== 1'b1) begin failures++; $display("FAIL reset_dp got=%b exp=1", dp_out); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    checks++; if (bcd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bcd_valid); end
    rst = 1'b0;
    first_valid = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n <= ND * DT) begin
        exp_an = ~(ND'(1) << ((n - 1) / DT));
        checks++; if (anode !== exp_an) begin failures++; $display("FAIL scan_anode n=%0d got=%b exp=%b", n, anode, exp_an); end
        checks++; if (seg !== 7'h40) begin failures++; $display("FAIL scan_zero_seg n=%0d got=%b exp=1000000", n, seg); end
      end
      if (bcd_valid === 1'b1) begin
        first_valid = n;
        break;
      end
    end
    checks++; if (first_valid != DW + 2) begin failures++; $display("FAIL first_valid_latency got=%0d exp=%0d", first_valid, DW + 2); end
  endtask

  task automatic test_decimal();
    bit ok;
    int unsigned v;
    for (int t = 0; t < 5; t++) begin
      v = (t == 0) ? 32'd1234 : $urandom_range(9999);
      blank_lz = (t == 0) ? 1'b0 : 1'($urandom_range(1));
      dp = 4'($urandom);
      settle(v, 1'b0, ok);
      checks++; if (!ok) begin failures++; $display("FAIL dec_valid_timeout v=%0d got=0 exp=1", v); end
      observe();
      checks++; if (obs_bad != 0) begin failures++; $display("FAIL dec_onehot v=%0d bad=%0d exp=0", v, obs_bad); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL dec_ovf v=%0d got=%b exp=0", v, overflow); end
      for (int k = 0; k < ND; k++) begin
        checks++;
        if (obs_seg[k] !== exp_seg(v, 1'b0, blank_lz, k)) begin
          failures++; $display("FAIL dec_seg v=%0d digit=%0d got=%b exp=%b", v, k, obs_seg[k], exp_seg(v, 1'b0, blank_lz, k));
        end
        checks++;
        if (obs_dp[k] !== ~dp[k]) begin
          failures++; $display("FAIL dec_dp v=%0d digit=%0d got=%b exp=%b", v, k, obs_dp[k], ~dp[k]);
        end
      end
    end
  endtask

  task automatic test_blank();
    bit ok;
    dp = '0;
    blank_lz = 1'b1;
    settle(32'd7, 1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL blank_valid_timeout got=0 exp=1"); end
    observe();
    for (int k = 0; k < ND; k++) begin
      checks++;
      if (obs_seg[k] !== exp_seg(7, 1'b0, 1'b1, k)) begin
        failures++; $display("FAIL blank_on digit=%0d got=%b exp=%b", k, obs_seg[k], exp_seg(7, 1'b0, 1'b1, k));
      end
    end
    blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    observe();
    for (int k = 0; k < ND; k++) begin
      checks++;
      if (obs_seg[k] !== exp_seg(7, 1'b0, 1'b0, k)) begin
        failures++; $display("FAIL blank_off digit=%0d got=%b exp=%b", k, obs_seg[k], exp_seg(7, 1'b0, 1'b0, k));
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    int unsigned v;
    for (int t = 0; t < 4; t++) begin
      case (t)
        0: v = 32'd10000;
        1: v = 32'd9999;
        default: v = $urandom_range(32'hFFFF_FFFF, 10000);
      endcase
      blank_lz = 1'($urandom_range(1));
      settle(v, 1'b0, ok);
      checks++; if (!ok) begin failures++; $display("FAIL ovf_valid_timeout v=%0d got=0 exp=1", v); end
      checks++;
      if (overflow !== exp_ovf(v, 1'b0)) begin
        failures++; $display("FAIL ovf_flag v=%0d got=%b exp=%b", v, overflow, exp_ovf(v, 1'b0));
      end
      observe();
      for (int k = 0; k < ND; k++) begin
        checks++;
        if (obs_seg[k] !== exp_seg(v, 1'b0, blank_lz, k)) begin
          failures++; $display("FAIL ovf_seg v=%0d digit=%0d got=%b exp=%b", v, k, obs_seg[k], exp_seg(v, 1'b0, blank_lz, k));
        end
      end
    end
  endtask

  task automatic test_hex();
    bit ok;
    int unsigned v;
    int gap;
    for (int t = 0; t < 3; t++) begin
      case (t)
        0: v = 32'h0000_BEEF;
        1: v = 32'h0001_BEEF;
        default: v = $urandom_range(16'hFFFF);
      endcase
      blank_lz = (t == 2) ? 1'b1 : 1'b0;
      settle(v, 1'b1, ok);
      checks++; if (!ok) begin failures++; $display("FAIL hex_valid_timeout v=%h got=0 exp=1", v); end
      checks++;
      if (overflow !== exp_ovf(v, 1'b1)) begin
        failures++; $display("FAIL hex_ovf v=%h got=%b exp=%b", v, overflow, exp_ovf(v, 1'b1));
      end
      gap = -1;
      for (int n = 1; n <= 10; n++) begin
        @(negedge clk);
        if (bcd_valid === 1'b1) begin
          gap = n;
          break;
        end
      end
      checks++; if (gap != 2) begin failures++; $display("FAIL hex_valid_gap got=%0d exp=2", gap); end
      observe();
      for (int k = 0; k < ND; k++) begin
        checks++;
        if (obs_seg[k] !== exp_seg(v, 1'b1, blank_lz, k)) begin
          failures++; $display("FAIL hex_seg v=%h digit=%0d got=%b exp=%b", v, k, obs_seg[k], exp_seg(v, 1'b1, blank_lz, k));
        end
      end
    end
  endtask

  task automatic test_mid_change();
    bit ok, ok2;
    blank_lz = 1'b0;
    settle(32'd1234, 1'b0, ok);
    wait_valid(ok2);
    checks++; if (!(ok && ok2)) begin failures++; $display("FAIL chg_valid_timeout got=0 exp=1"); end
    repeat (5) @(negedge clk);
    data_seg = 32'd5678;
    wait_valid(ok);
    checks++; if (!ok) begin failures++; $display("FAIL chg_valid2_timeout got=0 exp=1"); end
    observe();
    for (int k = 0; k < ND; k++) begin
      checks++;
      if (obs_seg[k] !== exp_seg(1234, 1'b0, 1'b0, k)) begin
        failures++; $display("FAIL chg_hold digit=%0d got=%b exp=%b", k, obs_seg[k], exp_seg(1234, 1'b0, 1'b0, k));
      end
    end
    wait_valid(ok);
    checks++; if (!ok) begin failures++; $display("FAIL chg_valid3_timeout got=0 exp=1"); end
    observe();
    for (int k = 0; k < ND; k++) begin
      checks++;
      if (obs_seg[k] !== exp_seg(5678, 1'b0, 1'b0, k)) begin
        failures++; $display("FAIL chg_new digit=%0d got=%b exp=%b", k, obs_seg[k], exp_seg(5678, 1'b0, 1'b0, k));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int first_valid;
    blank_lz = 1'b0;
    dp = '0;
    settle(32'd12345, 1'b0, ok);
    checks++; if (!ok || overflow !== 1'b1) begin failures++; $display("FAIL rmid_pre_ovf got=%b exp=1", overflow); end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (anode !== 4'hF) begin failures++; $display("FAIL rmid_anode got=%b exp=1111", anode); end
    checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL rmid_seg got=%b exp=1111111", seg); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rmid_ovf got=%b exp=0", overflow); end
    checks++; if (bcd_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", bcd_valid); end
    rst = 1'b0;
    first_valid = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 1) begin
        checks++; if (anode !== 4'b1110) begin failures++; $display("FAIL rmid_first_anode got=%b exp=1110", anode); end
        checks++; if (seg !== 7'h40) begin failures++; $display("FAIL rmid_cleared_seg got=%b exp=1000000", seg); end
      end
      if (bcd_valid === 1'b1) begin
        first_valid = n;
        break;
      end
    end
    checks++; if (first_valid != DW + 2) begin failures++; $display("FAIL rmid_latency got=%0d exp=%0d", first_valid, DW + 2); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL rmid_post_ovf got=%b exp=1", overflow); end
  endtask

  initial begin
    rst = 1'b1; data_seg = '0; hex_mode = 1'b0; blank_lz = 1'b0; dp = '0;
    test_reset();
    test_decimal();
    test_blank();
    test_overflow();
    test_hex();
    test_mid_change();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_mux.md
Name: seven_mux

Overview:
- Parametrised multiplexed 7-segment display driver for N digits.
- Converts a binary value to BCD (decimal mode) or nibbles (hex mode) using an iterative sequential converter, not combinational divide/modulo.
- Scans digits with a programmable per-digit dwell time. Supports leading-zero blanking, per-digit decimal points and overflow indication.
- Sits between the core's status/debug value and the board's anode/segment pins.

Parameters:
- NUM_DIGITS, 4, number of digits (1..8).
- DATA_W, 32, width of the input value (4..32).
- DIGIT_TICKS, 100000, clk cycles each digit is driven (>=2).
- ANODE_ACTIVE_LOW, 1, 1 = anode enable is 0, else 1.
- SEG_ACTIVE_LOW, 1, 1 = lit segment/dp is 0, else 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- data_seg  in  DATA_W  value to display; sampled at the start of each conversion
- hex_mode  in  1  1 = hexadecimal, 0 = decimal; sampled with data_seg
- blank_lz  in  1  1 = blank leading zero digits
- dp  in  NUM_DIGITS  decimal point request per digit; bit 0 is the rightmost digit
- anode  out  NUM_DIGITS  digit enables, one-hot active; bit 0 is the rightmost digit
- seg  out  7  segments {g,f,e,d,c,b,a}
- dp_out  out  1  decimal point of the active digit
- overflow  out  1  committed value does not fit in NUM_DIGITS digits
- bcd_valid  out  1  one-cycle pulse when a new value is committed to the display

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high. All state updates occur on posedge clk.
- Reset values (all outputs registered):
  - anode and seg all inactive; dp_out inactive; overflow=0; bcd_valid=0.
  - Display digit registers = 0; scan counter = 0; digit index = 0; converter in IDLE.
- Converter FSM, states IDLE, SHIFT, COMMIT:
  - IDLE: capture data_seg and hex_mode. Next state is SHIFT in decimal mode, COMMIT in hex mode.
  - SHIFT: double dabble, one bit per cycle, MSB first, over NUM_DIGITS BCD digits. Before each shift, add 3 to every BCD digit >= 5. Exactly DATA_W SHIFT cycles, then COMMIT.
  - COMMIT: copy all digits and the overflow flag to the display registers in a single cycle (no tearing). Pulse bcd_valid. Return to IDLE.
  - Conversion is free-running: restarts immediately after every COMMIT.
  - Latency from IDLE capture to commit: decimal = DATA_W+2 cycles; hex = 2 cycles.
- Overflow:
  - Decimal: set when the captured value > 10^NUM_DIGITS - 1. Compared at capture against a constant.
  - Hex: set when any captured bit at or above 4*NUM_DIGITS is nonzero.
  - When overflow is committed, every digit shows '-' (segment g only). Blanking is ignored; dp is still honoured.
- Scan:
  - Tick counter counts 0..DIGIT_TICKS-1 and wraps.
  - On wrap, digit index advances 0..NUM_DIGITS-1 and wraps to 0.
  - One cycle after rst deasserts, anode activates digit 0.
  - Exactly one anode bit is active at any time after reset.
- Leading-zero blanking: digit i>0 is blanked (all segments off) when blank_lz=1 and committed digits i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked.
- blank_lz and dp are sampled live each cycle into the registered outputs. There is no commit delay for them.
- Polarity: every output is inverted when the corresponding *_ACTIVE_LOW parameter = 1.
- Reset mid-conversion: abandon the conversion, clear the display registers, and restart from IDLE on the first cycle after reset deasserts.
- data_seg changing mid-conversion has no effect until the next IDLE capture.

Decomposition:
- Package seven_pkg:
  - 7-bit glyph constants (0-F, dash, blank), active-high.
  - hex_to_glyph function.
  - pow10 constant function.
  - Converter state enum.
- Sub-module seven_bin2bcd: the IDLE/SHIFT/COMMIT converter with a start/done handshake. The top level holds the scan counter, display registers and output encoding.

Test Plan:
- All tests use DIGIT_TICKS=4, NUM_DIGITS=4, DATA_W=32 unless noted.
- Reset, then hold data_seg=1234 decimal -> first bcd_valid within 34 cycles. Anode sequence 1110,1101,1011,0111, each held 4 cycles. seg = glyphs 4,3,2,1 (active-low: 0011001, 0110000, 0100100, 1111001).
- data_seg=7, blank_lz=1 -> digits 1..3 have seg=1111111 and digit 0 = 1011000. With blank_lz=0, digits 1..3 show 1000000.
- data_seg=10000 decimal -> overflow=1 and all digits seg=0111111. data_seg=9999 -> overflow=0.
- hex_mode=1, data_seg=32'h0000BEEF -> digits F,E,E,B; bcd_valid 2 cycles after capture. data_seg=32'h1BEEF -> overflow=1.
- Change data_seg from 1234 to 5678 during SHIFT -> display remains 1234 until the next COMMIT, then all four digits switch in the same cycle.
- Assert rst mid-SHIFT for 1 cycle -> outputs return to reset values the next cycle. Scan restarts at digit 0; the next bcd_valid arrives DATA_W+2 cycles after the IDLE capture.
